// File: rtl/fft_share_arb.sv
// rtl/fft_share_arb.sv - arbitrates one FFT engine between two overlap-save frame sources, tags frames in flight.
// Define FFT_ARB_PRIO_EN for fixed ch0 priority; default build is round-robin.
module fft_share_arb #(
  parameter int N    = 16,
  parameter int WN   = 9,
  parameter int TAGD = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  input  logic          i_start0,
  input  logic          i_start1,
  input  logic          i_valid0,
  input  logic          i_valid1,
  input  logic [WN-1:0] i_xI0,
  input  logic [WN-1:0] i_xQ0,
  input  logic [WN-1:0] i_xI1,
  input  logic [WN-1:0] i_xQ1,
  input  logic          i_fft_ready,
  output logic          o_fft_start,
  output logic          o_fft_valid,
  output logic [WN-1:0] o_fft_xI,
  output logic [WN-1:0] o_fft_xQ,
  output logic          o_fft_tag,
  input  logic          i_fft_out_start,
  output logic          o_out_tag,
  output logic          o_out_tag_valid,
  output logic          o_busy,
  output logic          o_err
);
  localparam int FL = 2 * N;
  localparam int CW = $clog2(FL);
  localparam int PW = $clog2(TAGD);
  localparam int OW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_gnt0, r_gnt1, r_winner;
  logic            w_gnt0_nxt, w_gnt1_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_fft_start, r_fft_valid, r_fft_tag;
  logic [WN-1:0]   r_fft_xI, r_fft_xQ;
  logic            r_tag_mem [TAGD];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]   r_occ;
  logic            r_out_tag, r_out_tag_valid, r_err;
`ifndef FFT_ARB_PRIO_EN
  logic            r_last_served;
`endif

  // Everything below the grant looks only at the granted channel's strobes.
  logic            w_g_req, w_g_start, w_g_valid;
  logic [WN-1:0]   w_g_xI, w_g_xQ;
  assign w_g_req   = r_winner ? i_req1   : i_req0;
  assign w_g_start = r_winner ? i_start1 : i_start0;
  assign w_g_valid = r_winner ? i_valid1 : i_valid0;
  assign w_g_xI    = r_winner ? i_xI1    : i_xI0;
  assign w_g_xQ    = r_winner ? i_xQ1    : i_xQ0;

  logic w_full, w_empty, w_pick, w_grant, w_push, w_release, w_fwd, w_last, w_pop, w_err_set;
  assign w_full  = (r_occ == OW'(TAGD));
  assign w_empty = (r_occ == '0);
`ifdef FFT_ARB_PRIO_EN
  assign w_pick = ~i_req0;
`else
  assign w_pick = (i_req0 & i_req1) ? ~r_last_served : i_req1;
`endif
  assign w_grant   = (r_state == S_IDLE) & (i_req0 | i_req1) & i_fft_ready & ~w_full;
  assign w_push    = (r_state == S_WAIT) & w_g_start;
  assign w_release = (r_state == S_WAIT) & ~w_g_start & ~w_g_req;
  assign w_fwd     = (r_state == S_STREAM) & w_g_valid;
  assign w_last    = w_fwd & (r_cnt == CW'(FL - 1));
  assign w_pop     = i_fft_out_start & ~w_empty;
  assign w_err_set = ((i_start0 | i_valid0) & ~r_gnt0) | ((i_start1 | i_valid1) & ~r_gnt1)
                   | ((r_state == S_STREAM) & w_g_start) | ((r_state == S_WAIT) & w_g_valid)
                   | (i_fft_out_start & w_empty);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_winner <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt0   <= w_gnt0_nxt;
      r_gnt1   <= w_gnt1_nxt;
      if (w_grant) r_winner <= w_pick;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_grant) w_state_nxt = S_WAIT;
      S_WAIT:   if (w_push) w_state_nxt = S_STREAM;
                else if (w_release) w_state_nxt = S_IDLE;
      S_STREAM: if (w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt0_nxt = r_gnt0;
    w_gnt1_nxt = r_gnt1;
    if (w_grant) begin
      w_gnt0_nxt = ~w_pick;
      w_gnt1_nxt = w_pick;
    end else if (w_release || w_last) begin
      w_gnt0_nxt = 1'b0;
      w_gnt1_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fft_start     <= 1'b0;
      r_fft_valid     <= 1'b0;
      r_fft_xI        <= '0;
      r_fft_xQ        <= '0;
      r_fft_tag       <= 1'b0;
      r_cnt           <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_occ           <= '0;
      r_out_tag       <= 1'b0;
      r_out_tag_valid <= 1'b0;
      r_err           <= 1'b0;
`ifndef FFT_ARB_PRIO_EN
      r_last_served   <= 1'b1;
`endif
    end else begin
      r_fft_start     <= w_push;
      r_fft_valid     <= w_fwd;
      r_out_tag_valid <= w_pop;
      if (w_fwd) begin
        r_fft_xI <= w_g_xI;
        r_fft_xQ <= w_g_xQ;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (w_push) begin
        r_fft_tag <= r_winner;
        r_cnt     <= '0;
        r_wr_ptr  <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_out_tag <= r_tag_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + PW'(1);
      end
      r_occ <= r_occ + OW'(w_push) - OW'(w_pop);
      if (w_err_set) r_err <= 1'b1;
`ifndef FFT_ARB_PRIO_EN
      if (w_last) r_last_served <= r_winner;
`endif
    end
  end

  // Tag storage needs no reset: a slot is only read after it was written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= r_winner;
  end

  assign o_gnt0          = r_gnt0;
  assign o_gnt1          = r_gnt1;
  assign o_fft_start     = r_fft_start;
  assign o_fft_valid     = r_fft_valid;
  assign o_fft_xI        = r_fft_xI;
  assign o_fft_xQ        = r_fft_xQ;
  assign o_fft_tag       = r_fft_tag;
  assign o_out_tag       = r_out_tag;
  assign o_out_tag_valid = r_out_tag_valid;
  assign o_busy          = (r_state != S_IDLE);
  assign o_err           = r_err;
endmodule
